// File: rtl/memory_ram_ws.sv
// Word-addressed data RAM with request/ready handshake, byte write enables and WAIT wait states.
// Optional MEMORY_RAM_WS_ERR_EN: flag and suppress accesses with iRAM_ADDR >= DEPTH.
module memory_ram_ws #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 1
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iRAM_CE,
  input  logic                iRAM_RD,
  input  logic                iRAM_WR,
  input  logic [DATA_W/8-1:0] iRAM_BE,
  input  logic [ADDR_W-1:0]   iRAM_ADDR,
  input  logic [DATA_W-1:0]   iRAM_DATA,
  output logic [DATA_W-1:0]   oRAM_DATA,
  output logic                oRAM_RDY,
  output logic                oRAM_ERR
);

  localparam int BE_W = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  stateT               state;
  stateT               stateNext;
  logic [3:0]          waitCnt;
  logic                opWr;
  logic [ADDR_W-1:0]   addrReg;
  logic [DATA_W-1:0]   dataReg;
  logic [BE_W-1:0]     beReg;
  logic                errReg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                doAccess;
  logic                addrOob;
  logic [IDX_W-1:0]    idx;

  // RESP also samples the bus so a held request restarts at once (one access per WAIT+2 cycles).
  assign accept   = ((state == IDLE) || (state == RESP)) && iRAM_CE && (iRAM_RD || iRAM_WR);
  assign doAccess = (state == BUSY) && (waitCnt == 4'd0);
  assign idx      = IDX_W'({1'b0, addrReg} % DEPTH_L);

`ifdef MEMORY_RAM_WS_ERR_EN
  assign addrOob = ({1'b0, addrReg} >= DEPTH_L);
`else
  assign addrOob = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = BUSY;
      BUSY:    if (waitCnt == 4'd0) stateNext = RESP;
      RESP:    stateNext = accept ? BUSY : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      waitCnt   <= 4'd0;
      opWr      <= 1'b0;
      addrReg   <= '0;
      dataReg   <= '0;
      beReg     <= '0;
      errReg    <= 1'b0;
      oRAM_DATA <= '0;
    end else begin
      if (accept) begin
        waitCnt <= WAIT_L;
        opWr    <= iRAM_WR;
        addrReg <= iRAM_ADDR;
        dataReg <= iRAM_DATA;
        beReg   <= iRAM_BE;
      end else if ((state == BUSY) && (waitCnt != 4'd0)) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (doAccess) begin
        errReg <= addrOob;
        if (!opWr) oRAM_DATA <= addrOob ? '0 : mem[idx];
      end
    end
  end

  // Storage is never reset; a reset mid-access leaves state IDLE so the write is dropped.
  always_ff @(posedge iCLK) begin
    if (doAccess && opWr && !addrOob) begin
      for (int k = 0; k < BE_W; k++) begin
        if (beReg[k]) mem[idx][8*k +: 8] <= dataReg[8*k +: 8];
      end
    end
  end

  assign oRAM_RDY = (state == RESP);
  assign oRAM_ERR = (state == RESP) && errReg;

endmodule
